ecc_banked_dpram: RTL

Single-clock, two-port (A, B) banked RAM with Hamming SECDED protection on every word, configurable bank count and read latency, and round-robin arbitration on bank conflicts. It is the next generation of the team's dual-port memory. It adds per-word ECC, error-injection hooks for verification, and error counters. It sits between two independent requesters and the storage array.

---
 rtl/ecc_dpram_pkg.sv | 62 ++++++
 rtl/ecc_secded_codec.sv | 55 +++++
 rtl/ecc_banked_dpram.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ecc_dpram_pkg.sv
// Shared SECDED helpers for the banked ECC dual-port RAM.
// Codeword layout: bit 0 is overall parity, bits 1..CW-1 are Hamming
// positions 1..CW-1 (powers of two hold check bits, the rest hold data).
package ecc_dpram_pkg;

  localparam int MAX_CW = 64;
  localparam int MAX_P  = 6;

  // Smallest P with 2^P >= dw + P + 1
  function automatic int calc_p(input int dw);
    int p;
    p = 1;
    for (int q = 31; q >= 1; q--) begin
      if ((1 << q) >= dw + q + 1) p = q;
    end
    return p;
  endfunction

  // Codeword width: data + Hamming check bits + overall parity
  function automatic int calc_cw(input int dw);
    return dw + calc_p(dw) + 1;
  endfunction

  localparam int DEF_DW = 8;
  localparam int DEF_CW = calc_cw(DEF_DW);

  typedef logic [DEF_CW-1:0] codeword_t;

  // Positions covered by Hamming check bit k; bit 0 (overall parity) is never covered
  function automatic logic [MAX_CW-1:0] hmask(input int k);
    logic [MAX_CW-1:0] m;
    m = '0;
    for (int i = 1; i < MAX_CW; i++) m[i] = (((i >> k) & 1) == 1);
    return m;
  endfunction

  localparam logic [MAX_P-1:0][MAX_CW-1:0] HMASK =
    {hmask(5), hmask(4), hmask(3), hmask(2), hmask(1), hmask(0)};

  // Codeword position of the j-th data bit (first non-power-of-two slots from 3 up)
  function automatic int data_pos(input int j);
    int n;
    int pos;
    n   = 0;
    pos = 0;
    for (int i = 3; i < MAX_CW; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (n == j && pos == 0) pos = i;
        n++;
      end
    end
    return pos;
  endfunction

  // 16-bit counter plus 0..2, clamped at all-ones
  function automatic logic [15:0] sat_add16(input logic [15:0] c, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, c} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/ecc_secded_codec.sv
// Combinational Hamming SECDED codec: encode path and decode/correct path.
module ecc_secded_codec
  import ecc_dpram_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0]              enc_data_i,
  output logic [calc_cw(DATA_WIDTH)-1:0]     enc_cw_o,
  input  logic [calc_cw(DATA_WIDTH)-1:0]     dec_cw_i,
  output logic [DATA_WIDTH-1:0]              dec_data_o,
  output logic                               dec_sec_o,
  output logic                               dec_ded_o
);

  localparam int P  = calc_p(DATA_WIDTH);
  localparam int CW = DATA_WIDTH + P + 1;

  logic [CW-1:0] enc_w;
  logic [CW-1:0] fixed_w;
  logic [P-1:0]  syn_w;
  logic          par_w;

  // Scatter data into its slots, then fill check bits and overall parity
  always_comb begin
    enc_w = '0;
    for (int j = 0; j < DATA_WIDTH; j++) enc_w[data_pos(j)] = enc_data_i[j];
    for (int k = 0; k < P; k++) enc_w[1 << k] = ^(enc_w & HMASK[k][CW-1:0]);
    enc_w[0] = ^enc_w[CW-1:1];
    enc_cw_o = enc_w;
  end

  // Syndrome points at the flipped position; overall parity separates 1 from 2 errors
  always_comb begin
    syn_w = '0;
    for (int k = 0; k < P; k++) syn_w[k] = ^(dec_cw_i & HMASK[k][CW-1:0]);
    par_w      = ^dec_cw_i;
    fixed_w    = dec_cw_i;
    dec_sec_o  = 1'b0;
    dec_ded_o  = 1'b0;
    dec_data_o = '0;
    if (syn_w != '0) begin
      // odd parity but a syndrome past the word end can only be a multi-bit error
      if (par_w && (int'(syn_w) < CW)) begin
        fixed_w   = fixed_w ^ ({{(CW-1){1'b0}}, 1'b1} << syn_w);
        dec_sec_o = 1'b1;
      end else begin
        dec_ded_o = 1'b1;
      end
    end else if (par_w) begin
      dec_sec_o = 1'b1;
    end
    for (int j = 0; j < DATA_WIDTH; j++) dec_data_o[j] = fixed_w[data_pos(j)];
  end

endmodule

// File: rtl/ecc_banked_dpram.sv
// Two-port banked RAM with SECDED per word, round-robin conflict arbitration,
// READ_LATENCY-deep registered read pipelines and saturating error counters.
// Port index 0 is A, 1 is B throughout.
module ecc_banked_dpram
  import ecc_dpram_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_DEPTH = 32,
  parameter int NUM_BANKS     = 4,
  parameter int READ_LATENCY  = 2,
  parameter int P             = calc_p(DATA_WIDTH),
  parameter int CW            = DATA_WIDTH + P + 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_a,
  input  logic                             req_b,
  input  logic                             we_a,
  input  logic                             we_b,
  input  logic [$clog2(ADDRESS_DEPTH)-1:0] addr_a,
  input  logic [$clog2(ADDRESS_DEPTH)-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0]            wdata_a,
  input  logic [DATA_WIDTH-1:0]            wdata_b,
  input  logic [CW-1:0]                    inj_a,
  input  logic [CW-1:0]                    inj_b,
  output logic                             ready_a,
  output logic                             ready_b,
  output logic                             rvalid_a,
  output logic                             rvalid_b,
  output logic [DATA_WIDTH-1:0]            rdata_a,
  output logic [DATA_WIDTH-1:0]            rdata_b,
  output logic                             err_sec_a,
  output logic                             err_sec_b,
  output logic                             err_ded_a,
  output logic                             err_ded_b,
  output logic [15:0]                      sec_count,
  output logic [15:0]                      ded_count
);

  localparam int AW   = $clog2(ADDRESS_DEPTH);
  localparam int BW   = $clog2(NUM_BANKS);
  localparam int RW   = AW - BW;
  localparam int ROWS = ADDRESS_DEPTH / NUM_BANKS;
  localparam int L    = READ_LATENCY;

  logic [1:0]                          req, we, gnt, acc, wr;
  logic [1:0][AW-1:0]                  addr;
  logic [1:0][DATA_WIDTH-1:0]          wdata;
  logic [1:0][CW-1:0]                  inj;
  logic [1:0][BW-1:0]                  bank;
  logic [1:0][RW-1:0]                  row;
  logic [1:0][CW-1:0]                  enc_cw, wr_cw, rd_cw;
  logic [1:0][DATA_WIDTH-1:0]          dec_data;
  logic [1:0]                          dec_sec, dec_ded;
  logic [NUM_BANKS-1:0][1:0][CW-1:0]   bank_rd;

  logic [1:0]                          s0_vld, s0_sec, s0_ded;
  logic [1:0][DATA_WIDTH-1:0]          s0_data;
  logic [L:1][1:0]                     vld_pipe_q, sec_pipe_q, ded_pipe_q;
  logic [L:1][1:0][DATA_WIDTH-1:0]     data_pipe_q;
  logic [1:0]                          sec_last, ded_last;

  logic                                conflict;
  logic                                prio_q, prio_d;
  logic [15:0]                         sec_cnt_q, sec_cnt_d, ded_cnt_q, ded_cnt_d;

  assign req   = {req_b, req_a};
  assign we    = {we_b, we_a};
  assign addr  = {addr_b, addr_a};
  assign wdata = {wdata_b, wdata_a};
  assign inj   = {inj_b, inj_a};

  // Round-robin on same-bank collisions; prio flips on every conflict cycle
  always_comb begin
    conflict = req[0] && req[1] && (bank[0] == bank[1]);
    gnt[0]   = !(conflict && prio_q);
    gnt[1]   = !(conflict && !prio_q);
    prio_d   = prio_q ^ conflict;
  end

  assign ready_a = gnt[0];
  assign ready_b = gnt[1];

  // Arbitration-priority register, A first out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end

  // Per-port address split, codec and stage-0 read result
  for (genvar p = 0; p < 2; p++) begin : g_port
    assign bank[p]  = addr[p][BW-1:0];
    assign row[p]   = addr[p][AW-1:BW];
    assign acc[p]   = req[p] & gnt[p];
    assign wr[p]    = acc[p] & we[p];
    assign wr_cw[p] = enc_cw[p] ^ inj[p];
    assign rd_cw[p] = bank_rd[bank[p]][p];

    // One codec per port: the write path encodes while the read path decodes
    ecc_secded_codec #(.DATA_WIDTH(DATA_WIDTH)) u_codec (
      .enc_data_i (wdata[p]),
      .enc_cw_o   (enc_cw[p]),
      .dec_cw_i   (rd_cw[p]),
      .dec_data_o (dec_data[p]),
      .dec_sec_o  (dec_sec[p]),
      .dec_ded_o  (dec_ded[p])
    );

    // Zero the payload of non-reads so the pipeline carries zeros while idle
    always_comb begin
      s0_vld[p]  = acc[p] & ~we[p];
      s0_data[p] = s0_vld[p] ? dec_data[p] : '0;
      s0_sec[p]  = s0_vld[p] & dec_sec[p];
      s0_ded[p]  = s0_vld[p] & dec_ded[p];
    end
  end

  // Bank storage; arbitration keeps the two ports off the same bank in a cycle
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [CW-1:0] mem_q [ROWS];

    // Write at the accept edge; storage is intentionally not reset
    always_ff @(posedge clk) begin
      if (wr[0] && bank[0] == BW'(g))      mem_q[row[0]] <= wr_cw[0];
      else if (wr[1] && bank[1] == BW'(g)) mem_q[row[1]] <= wr_cw[1];
    end

    assign bank_rd[g][0] = mem_q[row[0]];
    assign bank_rd[g][1] = mem_q[row[1]];
  end

  // Read pipeline: stage 1 loads at the accept edge, stage L drives the outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      sec_pipe_q  <= '0;
      ded_pipe_q  <= '0;
      data_pipe_q <= '0;
    end else begin
      vld_pipe_q[1]  <= s0_vld;
      sec_pipe_q[1]  <= s0_sec;
      ded_pipe_q[1]  <= s0_ded;
      data_pipe_q[1] <= s0_data;
      for (int s = 2; s <= L; s++) begin
        vld_pipe_q[s]  <= vld_pipe_q[s-1];
        sec_pipe_q[s]  <= sec_pipe_q[s-1];
        ded_pipe_q[s]  <= ded_pipe_q[s-1];
        data_pipe_q[s] <= data_pipe_q[s-1];
      end
    end
  end

  assign rvalid_a  = vld_pipe_q[L][0];
  assign rvalid_b  = vld_pipe_q[L][1];
  assign rdata_a   = data_pipe_q[L][0];
  assign rdata_b   = data_pipe_q[L][1];
  assign err_sec_a = sec_pipe_q[L][0];
  assign err_sec_b = sec_pipe_q[L][1];
  assign err_ded_a = ded_pipe_q[L][0];
  assign err_ded_b = ded_pipe_q[L][1];

  // Counters take the flags entering the output stage so they move with rvalid
  if (L == 1) begin : g_last_s0
    assign sec_last = s0_sec;
    assign ded_last = s0_ded;
  end else begin : g_last_pipe
    assign sec_last = sec_pipe_q[L-1];
    assign ded_last = ded_pipe_q[L-1];
  end

  // Saturating sum of both ports' error reports
  always_comb begin
    sec_cnt_d = sat_add16(sec_cnt_q, {1'b0, sec_last[0]} + {1'b0, sec_last[1]});
    ded_cnt_d = sat_add16(ded_cnt_q, {1'b0, ded_last[0]} + {1'b0, ded_last[1]});
  end

  // Error counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else begin
      sec_cnt_q <= sec_cnt_d;
      ded_cnt_q <= ded_cnt_d;
    end
  end

  assign sec_count = sec_cnt_q;
  assign ded_count = ded_cnt_q;

endmodule
